sram_emu: RTL

- Synthesizable responder for the board SRAM interface: emulates the two 16-bit async SRAM chips (chip 0 = data[15:0], chip 1 = data[31:16]) in FPGA block RAM.
- Connects directly to the system's ram_* controller ports in place of the external chips, for boards without SRAM and for simulation.
- Adds protocol checking: bus contention and illegal strobe combinations.
- Provides read and write access counters.

---
 rtl/sram_emu.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sram_emu.sv
// Block-RAM emulation of the two 16-bit async SRAM chips on the board bus,
// with per-lane write latching, write-first reads, protocol checks and access counters.
module sram_emu #(
  parameter int unsigned DEPTH_W = 12,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [17:0]      ram_addr,
  input  logic [31:0]      ram_data_in,
  input  logic             ram_data_is_output,
  input  logic [1:0]       ram_ce_n,
  input  logic [1:0]       ram_ub_n,
  input  logic [1:0]       ram_lb_n,
  input  logic [1:0]       ram_we_n,
  input  logic [1:0]       ram_oe_n,
  output logic [31:0]      ram_data_out,
  output logic [1:0]       ram_data_drive,
  output logic             err_contention,
  output logic             err_strobe,
  input  logic             err_clear,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int unsigned WORDS = 1 << DEPTH_W;

  typedef enum logic {W_IDLE, W_LAT} wstate_t;

  logic [DEPTH_W-1:0] addr;
  logic [1:0]         rd_cond;
  logic [1:0]         rd_prev;
  logic [1:0]         commit;
  logic [1:0]         strobe_bad;
  logic [1:0][15:0]   lane_out;
  logic [1:0]         drive_out;
  logic               unused_addr_hi;

  // Upper address bits alias onto the implemented depth.
  assign addr           = ram_addr[DEPTH_W-1:0];
  assign unused_addr_hi = ^ram_addr[17:DEPTH_W];

  for (genvar c = 0; c < 2; c++) begin : g_chip
    logic [15:0]        mem [WORDS];
    wstate_t            state;
    logic [DEPTH_W-1:0] w_addr;
    logic [15:0]        w_data;
    logic               w_ub_n;
    logic               w_lb_n;
    logic [15:0]        lane_q;
    logic               drive_q;
    logic [15:0]        rd_word;
    logic [15:0]        rd_merged;
    logic               ce;
    logic               we;
    logic               oe;

    assign ce = ~ram_ce_n[c];
    assign we = ~ram_we_n[c];
    assign oe = ~ram_oe_n[c];

    assign strobe_bad[c] = ce & we & oe;
    assign rd_cond[c]    = ce & oe & ~we;
    assign commit[c]     = (state == W_LAT) & ~we & ~reset;

    // A commit in the same cycle as a read to that word is forwarded (write-first).
    always_comb begin
      rd_word = mem[addr];
      if (commit[c] && (w_addr == addr)) begin
        if (!w_ub_n) rd_word[15:8] = w_data[15:8];
        if (!w_lb_n) rd_word[7:0]  = w_data[7:0];
      end
      rd_merged = {ram_ub_n[c] ? 8'h00 : rd_word[15:8],
                   ram_lb_n[c] ? 8'h00 : rd_word[7:0]};
    end

    always_ff @(posedge clk) begin
      if (commit[c]) begin
        if (!w_ub_n) mem[w_addr][15:8] <= w_data[15:8];
        if (!w_lb_n) mem[w_addr][7:0]  <= w_data[7:0];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= W_IDLE;
        w_addr <= '0;
        w_data <= '0;
        w_ub_n <= 1'b1;
        w_lb_n <= 1'b1;
      end else begin
        case (state)
          W_IDLE: begin
            if (ce && we && !oe) begin
              state  <= W_LAT;
              w_addr <= addr;
              w_data <= ram_data_in[16*c +: 16];
              w_ub_n <= ram_ub_n[c];
              w_lb_n <= ram_lb_n[c];
            end
          end
          W_LAT: begin
            if (!we || !ce) begin
              state <= W_IDLE;
            end else if (!oe) begin
              w_addr <= addr;
              w_data <= ram_data_in[16*c +: 16];
              w_ub_n <= ram_ub_n[c];
              w_lb_n <= ram_lb_n[c];
            end
          end
          default: state <= W_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        lane_q  <= '0;
        drive_q <= 1'b0;
      end else begin
        drive_q <= rd_cond[c];
        if (rd_cond[c]) lane_q <= rd_merged;
      end
    end

    assign lane_out[c]  = lane_q;
    assign drive_out[c] = drive_q;
  end

  assign ram_data_out   = lane_out;
  assign ram_data_drive = drive_out;

  // Lanes completing together count as one 32-bit access.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_prev        <= '0;
      rd_count       <= '0;
      wr_count       <= '0;
      err_strobe     <= 1'b0;
      err_contention <= 1'b0;
    end else begin
      rd_prev <= rd_cond;
      if (|(rd_cond & ~rd_prev)) rd_count <= rd_count + CNT_W'(1);
      if (|commit)               wr_count <= wr_count + CNT_W'(1);
      if (|strobe_bad)           err_strobe <= 1'b1;
      else if (err_clear)        err_strobe <= 1'b0;
      if (ram_data_is_output && (|drive_out)) err_contention <= 1'b1;
      else if (err_clear)                     err_contention <= 1'b0;
    end
  end

endmodule
